iob_wb_bridge: RTL

IOB_WB_BRIDGE -- requirements
Module: iob_wb_bridge

---
 rtl/iob_wb_bridge.sv | 132 +++++++++++++
 1 files changed

// File: rtl/iob_wb_bridge.sv
// IOb-native slave to Wishbone classic master bridge, one outstanding request.
// Optional Wishbone wait timeout enabled by defining IOB_WB_BRIDGE_TIMEOUT_EN.
module iob_wb_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  s_valid,
   input  logic [ADDR_W-1:0]                     s_address,
   input  logic [DATA_W-1:0]                     s_wdata,
   input  logic [DATA_W/8-1:0]                   s_wstrb,
   output logic [DATA_W-1:0]                     s_rdata,
   output logic                                  s_ready,
   output logic                                  s_err,
   output logic [ADDR_W-$clog2(DATA_W/8)-1:0]    wb_adr_o,
   output logic [DATA_W-1:0]                     wb_dat_o,
   output logic [DATA_W/8-1:0]                   wb_sel_o,
   output logic                                  wb_we_o,
   output logic                                  wb_cyc_o,
   output logic                                  wb_stb_o,
   output logic [2:0]                            wb_cti_o,
   output logic [1:0]                            wb_bte_o,
   input  logic [DATA_W-1:0]                     wb_dat_i,
   input  logic                                  wb_ack_i,
   input  logic                                  wb_err_i
);
   // state | meaning
   // IDLE  | waiting for s_valid, request captured on acceptance
   // BUS   | Wishbone cycle in flight, waiting for ack/err (or timeout)
   // RESP  | one-cycle s_ready pulse back to the IOb master
   localparam int SEL_W  = DATA_W / 8;
   localparam int OFF_W  = $clog2(SEL_W);
   localparam int WADR_W = ADDR_W - OFF_W;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUS  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [WADR_W-1:0] adr_q;
   logic [DATA_W-1:0] dat_q;
   logic [DATA_W-1:0] rdata_q;
   logic [SEL_W-1:0]  sel_q;
   logic              we_q;
   logic              err_q;
   logic              in_bus;
   logic              timeout;
   logic              term_err;
   logic              term;
   logic              unused_addr_bits;

   // Byte-offset bits never reach the word-addressed bus.
   assign unused_addr_bits = ^s_address;

   assign in_bus = (state_q == S_BUS);

`ifdef IOB_WB_BRIDGE_TIMEOUT_EN
   localparam int              CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q;

   // Counter holds (BUS cycle - 1); a real termination on the last cycle wins.
   assign timeout = in_bus && !wb_ack_i && !wb_err_i && (cnt_q == CNT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if ((state_q == S_IDLE) && s_valid) begin
         cnt_q <= '0;
      end else if (in_bus && !wb_ack_i && !wb_err_i) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end
`else
   localparam int unused_timeout = TIMEOUT;
   assign timeout = 1'b0;
`endif

   assign term_err = wb_err_i | timeout;
   assign term     = in_bus && (wb_ack_i || term_err);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (s_valid) state_d = S_BUS;
         S_BUS:   if (term)    state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         adr_q   <= '0;
         dat_q   <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if ((state_q == S_IDLE) && s_valid) begin
            adr_q <= s_address[ADDR_W-1:OFF_W];
            dat_q <= s_wdata;
            we_q  <= |s_wstrb;
            sel_q <= (|s_wstrb) ? s_wstrb : '1;
         end
         if (term) begin
            err_q   <= term_err;
            rdata_q <= (!term_err && !we_q) ? wb_dat_i : '0;
         end
      end
   end

   assign wb_cyc_o = in_bus;
   assign wb_stb_o = in_bus;
   assign wb_adr_o = adr_q;
   assign wb_dat_o = dat_q;
   assign wb_sel_o = sel_q;
   assign wb_we_o  = we_q;
   assign wb_cti_o = 3'b000;
   assign wb_bte_o = 2'b00;

   assign s_ready  = (state_q == S_RESP);
   assign s_err    = s_ready & err_q;
   assign s_rdata  = rdata_q;

endmodule
